lsu_pipeline: RTL and testbench
===============================

Name: lsu_pipeline

Overview:
Parametrised load/store unit in the memory stage of the 5-stage RISC-V core. It replaces the fixed single-cycle mem_addr/mem_write/mem_wen port with a request/grant/response bus that tolerates variable latency. It supports byte, halfword and word accesses with byte enables, load sign/zero extension, misalignment detection and a bus timeout. It stalls the pipeline until each access completes.

Parameters:
ADDR_W, 32, bus address width (ALUResultM low ADDR_W bits used)
TIMEOUT, 16, max cycles waiting for grant or rvalid before bus error (>=2)
CNT_W, 5, timeout counter width, must hold TIMEOUT

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
ReqValidM  in  1  memory-stage instruction is a load or store
ReqWriteM  in  1  1=store, 0=load
Funct3M  in  3  access size/sign (RV32I funct3)
ALUResultM  in  32  effective address
WriteDataM  in  32  store data, unaligned in low bits
StallM  out  1  hold fetch..memory stages
LoadDataM  out  32  extended load data, valid in DONE cycle
MisalignM  out  1  one-cycle pulse: misaligned access rejected
BusErrM  out  1  one-cycle pulse in DONE: access timed out
bus_req  out  1  request valid
bus_we  out  1  write enable
bus_addr  out  ADDR_W  word-aligned address (low 2 bits 0)
bus_be  out  4  byte enables
bus_wdata  out  32  lane-shifted store data
bus_gnt  in  1  request accepted this cycle
bus_rvalid  in  1  read data valid
bus_rdata  in  32  read data

Behaviour:
- Reset: state IDLE. All outputs 0. Counter 0. Registered bus fields 0.
- FSM: IDLE, REQ, WAIT, DONE.
- IDLE, ReqValidM=1 and aligned: latch addr/be/wdata/we/funct3 and go to REQ. StallM=1 combinationally this cycle.
- IDLE, misaligned: no bus access. MisalignM=1 for that cycle. StallM=0. Stay IDLE.
- Misaligned means: halfword with addr[0]=1, or word with addr[1:0]!=0. funct3 011/110/111 are treated as misaligned. Loads with 011 are also illegal.
- REQ: bus_req=1 with stable bus fields until bus_gnt.
  - Grant on a store: go to DONE.
  - Grant on a load: go to WAIT. Counter clears on grant.
- WAIT: on bus_rvalid, capture the extended data into LoadDataM and go to DONE.
- StallM=1 in REQ and WAIT. StallM=0 in DONE, so the pipeline advances exactly one cycle.
- DONE always returns to IDLE. ReqValidM is ignored in DONE, because it still shows the completed instruction.
- bus_be and wdata:
  - SB: be=1<<addr[1:0]; wdata=byte replicated x4.
  - SH: be=0011 or 1100; wdata=half replicated x2.
  - SW: be=1111.
  - Loads drive the same be.
- Load extension: select the byte or halfword by addr[1:0].
  - LB/LH sign-extend.
  - LBU/LHU zero-extend.
  - LW passes the word through.
- LoadDataM holds its value until the next load completes. For stores it is unchanged.
- Timeout: the counter increments each cycle in REQ or WAIT. When it reaches TIMEOUT-1 without the awaited event:
  - drop bus_req and go to DONE;
  - BusErrM=1 in DONE;
  - LoadDataM=0.
- Simultaneous bus_gnt and timeout expiry: the grant wins.
- bus_rvalid outside WAIT is ignored. This includes a late response after a timeout or reset.
- Reset mid-operation: next edge forces IDLE and bus_req=0. The pending access is abandoned with no error pulse.

Test Plan:
- LW to addr 0x100, gnt after 2 cycles, rvalid 3 cycles later with 0xDEADBEEF:
  - bus_be=1111, bus_addr=0x100;
  - StallM high 6 cycles, then DONE;
  - LoadDataM=0xDEADBEEF.
- SB data 0x000000A5 to 0x203, immediate gnt:
  - bus_be=1000, bus_wdata=0xA5A5A5A5, bus_we=1;
  - total stall 2 cycles;
  - no rvalid needed.
- LH from 0x102 with rdata 0x80017FFF gives LoadDataM=0xFFFF8001. LHU from the same address gives 0x00008001.
- LW to 0x101:
  - MisalignM pulse for 1 cycle;
  - bus_req never asserted;
  - StallM=0.
- LB with gnt but no rvalid, TIMEOUT=16:
  - BusErrM pulses after 16 WAIT cycles;
  - LoadDataM=0;
  - a subsequent late rvalid is ignored.
- rst asserted in WAIT: next cycle state IDLE, bus_req=0, StallM=0. A following LW completes normally.

Source files
------------

// File: rtl/lsu_pipeline.sv
// lsu_pipeline: load/store unit for the memory stage of the 5-stage RISC-V core.
// Sends each load or store over a request/grant/response bus and holds the
// pipeline until the access completes. Handles byte, halfword and word sizes,
// load sign/zero extension, misalignment rejection and a bus timeout.
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   ReqValidM          memory-stage instruction is a load or store
//   ReqWriteM          1 = store, 0 = load
//   Funct3M            RV32I funct3 (access size / sign)
//   ALUResultM         effective address
//   WriteDataM         store data, unaligned in the low bits
//   StallM             holds the fetch..memory stages
//   LoadDataM          extended load data, valid in the DONE cycle
//   MisalignM          one-cycle pulse when a misaligned access is rejected
//   BusErrM            one-cycle pulse in DONE when the access timed out
//   bus_req/bus_we/bus_addr/bus_be/bus_wdata   request channel
//   bus_gnt            request accepted this cycle
//   bus_rvalid/bus_rdata                       read response channel
//   dbgState           current FSM state (0 IDLE, 1 REQ, 2 WAIT, 3 DONE)
//
// Bus handshake: a request transfers on a cycle where bus_req and bus_gnt are
// both high; until then bus_req and every bus field stay stable. A read
// response transfers on a cycle where bus_rvalid is high while in WAIT; there
// is no backpressure on the response and bus_rvalid seen in any other state is
// dropped.
module lsu_pipeline #(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ReqValidM,
    input  logic              ReqWriteM,
    input  logic [2:0]        Funct3M,
    input  logic [31:0]       ALUResultM,
    input  logic [31:0]       WriteDataM,
    output logic              StallM,
    output logic [31:0]       LoadDataM,
    output logic              MisalignM,
    output logic              BusErrM,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [3:0]        bus_be,
    output logic [31:0]       bus_wdata,
    input  logic              bus_gnt,
    input  logic              bus_rvalid,
    input  logic [31:0]       bus_rdata,
    output logic [1:0]        dbgState
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } lsuStateT;

    lsuStateT         state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       funct3Q;
    logic [1:0]       addrLoQ;

    logic        reqMisaligned;
    logic        acceptReq;
    logic [3:0]  reqBe;
    logic [31:0] reqWdata;
    logic        timeoutHit;
    logic [31:0] rdShifted;
    logic [31:0] loadExt;

    // funct3[1:0] encodes size; 011/110/111 have no legal RV32I access, so
    // they are rejected through the misalignment path.
    always_comb begin
        reqMisaligned = 1'b0;
        case (Funct3M)
            3'b000, 3'b100: reqMisaligned = 1'b0;
            3'b001, 3'b101: reqMisaligned = ALUResultM[0];
            3'b010:         reqMisaligned = |ALUResultM[1:0];
            default:        reqMisaligned = 1'b1;
        endcase
    end

    always_comb begin
        reqBe    = 4'b1111;
        reqWdata = WriteDataM;
        case (Funct3M[1:0])
            2'b00: begin
                reqBe    = 4'b0001 << ALUResultM[1:0];
                reqWdata = {4{WriteDataM[7:0]}};
            end
            2'b01: begin
                reqBe    = ALUResultM[1] ? 4'b1100 : 4'b0011;
                reqWdata = {2{WriteDataM[15:0]}};
            end
            default: begin
                reqBe    = 4'b1111;
                reqWdata = WriteDataM;
            end
        endcase
    end

    assign acceptReq  = !rst && (state == S_IDLE) && ReqValidM && !reqMisaligned;
    assign MisalignM  = !rst && (state == S_IDLE) && ReqValidM && reqMisaligned;
    // Stall starts in the accepting IDLE cycle so the instruction is held;
    // DONE leaves it low so the pipeline advances exactly once.
    assign StallM     = acceptReq || (!rst && ((state == S_REQ) || (state == S_WAIT)));
    assign timeoutHit = (cnt == CNT_W'(TIMEOUT - 1));
    assign dbgState   = state;

    // Move the addressed lane down to bit 0, then extend by the latched funct3.
    assign rdShifted = bus_rdata >> {addrLoQ, 3'b000};

    always_comb begin
        loadExt = bus_rdata;
        case (funct3Q)
            3'b000:  loadExt = {{24{rdShifted[7]}}, rdShifted[7:0]};
            3'b100:  loadExt = {24'h0, rdShifted[7:0]};
            3'b001:  loadExt = {{16{rdShifted[15]}}, rdShifted[15:0]};
            3'b101:  loadExt = {16'h0, rdShifted[15:0]};
            default: loadExt = bus_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            funct3Q   <= 3'b000;
            addrLoQ   <= 2'b00;
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_be    <= 4'b0000;
            bus_wdata <= 32'h0;
            LoadDataM <= 32'h0;
            BusErrM   <= 1'b0;
        end else begin
            BusErrM <= 1'b0;
            case (state)
                S_IDLE: begin
                    cnt <= '0;
                    if (acceptReq) begin
                        bus_req   <= 1'b1;
                        bus_we    <= ReqWriteM;
                        bus_addr  <= {ALUResultM[ADDR_W-1:2], 2'b00};
                        bus_be    <= reqBe;
                        bus_wdata <= reqWdata;
                        funct3Q   <= Funct3M;
                        addrLoQ   <= ALUResultM[1:0];
                        state     <= S_REQ;
                    end
                end
                S_REQ: begin
                    // A grant in the expiry cycle still completes the access.
                    if (bus_gnt) begin
                        bus_req <= 1'b0;
                        cnt     <= '0;
                        state   <= bus_we ? S_DONE : S_WAIT;
                    end else if (timeoutHit) begin
                        bus_req   <= 1'b0;
                        BusErrM   <= 1'b1;
                        LoadDataM <= 32'h0;
                        state     <= S_DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_WAIT: begin
                    if (bus_rvalid) begin
                        LoadDataM <= loadExt;
                        state     <= S_DONE;
                    end else if (timeoutHit) begin
                        BusErrM   <= 1'b1;
                        LoadDataM <= 32'h0;
                        state     <= S_DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    // ReqValidM still shows the finished instruction here.
                    cnt   <= '0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_pipeline.sv
// tb_lsu_pipeline: directed bench for lsu_pipeline with hand-computed
// expectations, a bus responder inside the access task, and a queue of
// expected LoadDataM values consumed at each DONE cycle.
module tb_lsu_pipeline;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    logic        clk;
    logic        rst;
    logic        ReqValidM;
    logic        ReqWriteM;
    logic [2:0]  Funct3M;
    logic [31:0] ALUResultM;
    logic [31:0] WriteDataM;
    logic        StallM;
    logic [31:0] LoadDataM;
    logic        MisalignM;
    logic        BusErrM;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_gnt;
    logic        bus_rvalid;
    logic [31:0] bus_rdata;
    logic [1:0]  dbgState;

    int numChecks = 0;
    int numFails  = 0;
    logic [31:0] expQ[$];

    lsu_pipeline #(.ADDR_W(32), .TIMEOUT(16), .CNT_W(5)) dut (
        .clk        (clk),
        .rst        (rst),
        .ReqValidM  (ReqValidM),
        .ReqWriteM  (ReqWriteM),
        .Funct3M    (Funct3M),
        .ALUResultM (ALUResultM),
        .WriteDataM (WriteDataM),
        .StallM     (StallM),
        .LoadDataM  (LoadDataM),
        .MisalignM  (MisalignM),
        .BusErrM    (BusErrM),
        .bus_req    (bus_req),
        .bus_we     (bus_we),
        .bus_addr   (bus_addr),
        .bus_be     (bus_be),
        .bus_wdata  (bus_wdata),
        .bus_gnt    (bus_gnt),
        .bus_rvalid (bus_rvalid),
        .bus_rdata  (bus_rdata),
        .dbgState   (dbgState)
    );

    // Clock and watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog expired");
    end

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        numChecks++;
        if (got !== exp) begin
            numFails++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one access and plays the bus: grant on the gntWait-th cycle of
    // bus_req (negative = never), rvalid on the rvWait-th cycle after the grant
    // (negative = never). Returns stall count, error flag and the request fields.
    task automatic runAccess(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                             input logic [31:0] wd, input int gntWait, input int rvWait,
                             input logic [31:0] rdata, output int stalls, output logic err,
                             output logic [3:0] be, output logic [31:0] baddr,
                             output logic [31:0] bwdata, output logic bwe);
        int   reqIdx;
        int   waitIdx;
        logic granted;
        logic done;
        reqIdx = 0; waitIdx = 0; granted = 1'b0; done = 1'b0;
        stalls = 0; err = 1'b0; be = 4'h0; baddr = 32'h0; bwdata = 32'h0; bwe = 1'b0;
        ReqValidM = 1'b1; ReqWriteM = we; Funct3M = f3; ALUResultM = addr; WriteDataM = wd;
        for (int cyc = 0; cyc < 100 && !done; cyc++) begin
            bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = 32'h0;
            if (bus_req) begin
                if (reqIdx == 0) begin
                    be = bus_be; baddr = bus_addr; bwdata = bus_wdata; bwe = bus_we;
                end
                if (reqIdx == gntWait) begin
                    bus_gnt = 1'b1;
                    granted = 1'b1;
                end
                reqIdx++;
            end else if (granted && !we) begin
                if (waitIdx == rvWait) begin
                    bus_rvalid = 1'b1;
                    bus_rdata  = rdata;
                end
                waitIdx++;
            end
            #1;
            if (StallM) stalls++;
            if (dbgState == ST_DONE) begin
                done = 1'b1;
                err  = BusErrM;
                checkVal("load_data", LoadDataM, expQ.pop_front());
                checkVal("misalign_in_done", {31'h0, MisalignM}, 32'h0);
            end
            tick();
        end
        bus_gnt = 1'b0; bus_rvalid = 1'b0; ReqValidM = 1'b0;
        checkVal("access_done", {31'h0, done}, 32'h1);
        checkVal("back_to_idle", {30'h0, dbgState}, {30'h0, ST_IDLE});
    endtask

    int          stalls;
    logic        err;
    logic [3:0]  be;
    logic [31:0] baddr;
    logic [31:0] bwdata;
    logic        bwe;

    // Misaligned vectors: {write, funct3, addr}
    logic [35:0] misTab[4];

    initial begin
        rst = 1'b1; ReqValidM = 1'b0; ReqWriteM = 1'b0; Funct3M = 3'b000;
        ALUResultM = 32'h0; WriteDataM = 32'h0;
        bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        checkVal("rst_state", {30'h0, dbgState}, {30'h0, ST_IDLE});
        checkVal("rst_stall", {31'h0, StallM}, 32'h0);
        checkVal("rst_req", {31'h0, bus_req}, 32'h0);
        checkVal("rst_be", {28'h0, bus_be}, 32'h0);
        checkVal("rst_addr", bus_addr, 32'h0);
        checkVal("rst_loaddata", LoadDataM, 32'h0);
        checkVal("rst_buserr", {31'h0, BusErrM}, 32'h0);
        checkVal("rst_misalign", {31'h0, MisalignM}, 32'h0);
        rst = 1'b0;
        tick();

        // LW 0x100: grant on second REQ cycle, rvalid on third WAIT cycle
        expQ.push_back(32'hDEADBEEF);
        runAccess(1'b0, 3'b010, 32'h100, 32'h0, 1, 2, 32'hDEADBEEF, stalls, err, be, baddr, bwdata, bwe);
        checkVal("lw_be", {28'h0, be}, 32'hF);
        checkVal("lw_addr", baddr, 32'h100);
        checkVal("lw_we", {31'h0, bwe}, 32'h0);
        checkVal("lw_stall", stalls, 6);
        checkVal("lw_err", {31'h0, err}, 32'h0);

        // SB 0xA5 to 0x203, immediate grant; LoadDataM unchanged
        expQ.push_back(32'hDEADBEEF);
        runAccess(1'b1, 3'b000, 32'h203, 32'h000000A5, 0, -1, 32'h0, stalls, err, be, baddr, bwdata, bwe);
        checkVal("sb_be", {28'h0, be}, 32'h8);
        checkVal("sb_wdata", bwdata, 32'hA5A5A5A5);
        checkVal("sb_we", {31'h0, bwe}, 32'h1);
        checkVal("sb_addr", baddr, 32'h200);
        checkVal("sb_stall", stalls, 2);

        // LH / LHU from 0x102
        expQ.push_back(32'hFFFF8001);
        runAccess(1'b0, 3'b001, 32'h102, 32'h0, 0, 0, 32'h80017FFF, stalls, err, be, baddr, bwdata, bwe);
        checkVal("lh_be", {28'h0, be}, 32'hC);
        checkVal("lh_stall", stalls, 3);
        expQ.push_back(32'h00008001);
        runAccess(1'b0, 3'b101, 32'h102, 32'h0, 0, 0, 32'h80017FFF, stalls, err, be, baddr, bwdata, bwe);

        // LB 0x101 (byte 0x83 sign-extended), LBU 0x103 (byte 0x11)
        expQ.push_back(32'hFFFFFF83);
        runAccess(1'b0, 3'b000, 32'h101, 32'h0, 0, 0, 32'h11228344, stalls, err, be, baddr, bwdata, bwe);
        checkVal("lb_be", {28'h0, be}, 32'h2);
        expQ.push_back(32'h00000011);
        runAccess(1'b0, 3'b100, 32'h103, 32'h0, 2, 1, 32'h11228344, stalls, err, be, baddr, bwdata, bwe);
        checkVal("lbu_stall", stalls, 6);

        // SH 0xBEEF to 0x302
        expQ.push_back(32'h00000011);
        runAccess(1'b1, 3'b001, 32'h302, 32'h1234BEEF, 0, -1, 32'h0, stalls, err, be, baddr, bwdata, bwe);
        checkVal("sh_be", {28'h0, be}, 32'hC);
        checkVal("sh_wdata", bwdata, 32'hBEEFBEEF);
        checkVal("sh_addr", baddr, 32'h300);

        // Misaligned / illegal accesses: pulse, no stall, no request
        misTab[0] = {1'b0, 3'b010, 32'h101};
        misTab[1] = {1'b1, 3'b001, 32'h103};
        misTab[2] = {1'b0, 3'b011, 32'h000};
        misTab[3] = {1'b1, 3'b110, 32'h004};
        for (int i = 0; i < 4; i++) begin
            ReqValidM = 1'b1; ReqWriteM = misTab[i][35]; Funct3M = misTab[i][34:32];
            ALUResultM = misTab[i][31:0];
            #1;
            checkVal($sformatf("mis%0d_pulse", i), {31'h0, MisalignM}, 32'h1);
            checkVal($sformatf("mis%0d_stall", i), {31'h0, StallM}, 32'h0);
            tick();
            checkVal($sformatf("mis%0d_req", i), {31'h0, bus_req}, 32'h0);
            checkVal($sformatf("mis%0d_state", i), {30'h0, dbgState}, {30'h0, ST_IDLE});
            ReqValidM = 1'b0;
            #1;
            checkVal($sformatf("mis%0d_drop", i), {31'h0, MisalignM}, 32'h0);
            tick();
        end

        // LB timeout in WAIT: 1 IDLE + 1 REQ + 16 WAIT stall cycles
        expQ.push_back(32'h00000000);
        runAccess(1'b0, 3'b000, 32'h000, 32'h0, 0, -1, 32'h0, stalls, err, be, baddr, bwdata, bwe);
        checkVal("to_wait_err", {31'h0, err}, 32'h1);
        checkVal("to_wait_stall", stalls, 18);
        bus_rvalid = 1'b1; bus_rdata = 32'hFFFFFFFF;
        tick();
        bus_rvalid = 1'b0;
        checkVal("late_rvalid_data", LoadDataM, 32'h0);
        checkVal("late_rvalid_state", {30'h0, dbgState}, {30'h0, ST_IDLE});
        checkVal("late_rvalid_err", {31'h0, BusErrM}, 32'h0);

        // SW with no grant: 16 REQ cycles then error
        expQ.push_back(32'h00000000);
        runAccess(1'b1, 3'b010, 32'h040, 32'h55AA55AA, -1, -1, 32'h0, stalls, err, be, baddr, bwdata, bwe);
        checkVal("to_req_err", {31'h0, err}, 32'h1);
        checkVal("to_req_stall", stalls, 17);

        // SW granted in the expiry cycle: grant wins
        expQ.push_back(32'h00000000);
        runAccess(1'b1, 3'b010, 32'h044, 32'h01020304, 15, -1, 32'h0, stalls, err, be, baddr, bwdata, bwe);
        checkVal("gnt_at_expiry_err", {31'h0, err}, 32'h0);
        checkVal("gnt_at_expiry_stall", stalls, 17);
        checkVal("gnt_at_expiry_wdata", bwdata, 32'h01020304);

        // Reset while in WAIT
        ReqValidM = 1'b1; ReqWriteM = 1'b0; Funct3M = 3'b010; ALUResultM = 32'h10;
        tick();
        bus_gnt = 1'b1;
        tick();
        bus_gnt = 1'b0;
        tick();
        checkVal("rstw_in_wait", {30'h0, dbgState}, {30'h0, ST_WAIT});
        rst = 1'b1;
        tick();
        checkVal("rstw_state", {30'h0, dbgState}, {30'h0, ST_IDLE});
        checkVal("rstw_req", {31'h0, bus_req}, 32'h0);
        checkVal("rstw_stall", {31'h0, StallM}, 32'h0);
        checkVal("rstw_err", {31'h0, BusErrM}, 32'h0);
        rst = 1'b0; ReqValidM = 1'b0;
        bus_rvalid = 1'b1; bus_rdata = 32'hCAFEF00D;
        tick();
        bus_rvalid = 1'b0;
        checkVal("rstw_late_data", LoadDataM, 32'h0);
        checkVal("rstw_late_err", {31'h0, BusErrM}, 32'h0);

        // LW after reset completes normally
        expQ.push_back(32'h12345678);
        runAccess(1'b0, 3'b010, 32'h008, 32'h0, 0, 1, 32'h12345678, stalls, err, be, baddr, bwdata, bwe);
        checkVal("post_rst_stall", stalls, 4);
        checkVal("post_rst_addr", baddr, 32'h8);
        checkVal("post_rst_err", {31'h0, err}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", numChecks, numFails);
        $finish;
    end

endmodule
